hcsr04_scheduler: RTL and testbench
===================================

# hcsr04_scheduler

Round-robin measurement scheduler for up to N HC-SR04 ultrasonic sensors sharing one timing engine. It picks the next enabled sensor, drives that sensor's 10 µs trigger, times its echo pulse (with timeout), reports the result with a one-cycle valid strobe, then enforces a guard interval before the next sensor. This prevents acoustic crosstalk between sensors. It sits between the sensor pins and the distance/filter logic and replaces per-sensor free-running capture.

## Interface
- T_CLK, 10, clock period in ns
- N_SENSORS, 4, number of sensor channels, 1..8
- TRIG_US, 10, trigger pulse width in µs
- TIMEOUT_US, 38000, max wait for echo rise and max echo width, in µs
- GUARD_US, 10000, idle gap after each measurement, in µs

Ports:
- i_clk  in  1  system clock
- i_rstn  in  1  asynchronous, active-low reset
- i_enable  in  1  run scheduling; 0 = stop after current measurement
- i_mask  in  N_SENSORS  per-sensor poll enable
- i_echo  in  N_SENSORS  raw echo pins (asynchronous)
- o_trigger  out  N_SENSORS  trigger pins; at most one bit high
- o_valid  out  1  one-cycle result strobe
- o_sensor_id  out  $clog2(N_SENSORS) (min 1)  channel of the result
- o_echo_time  out  22  echo width in clock cycles
- o_timeout  out  1  result is a timeout; qualified by o_valid
- o_busy  out  1  high in any state other than IDLE

## Operation
- Derived cycle counts: TRIG_CYC = TRIG_US*1000/T_CLK, TO_CYC = TIMEOUT_US*1000/T_CLK, GRD_CYC = GUARD_US*1000/T_CLK.
- Elaboration fails if TO_CYC >= 2^22.
- Each i_echo bit passes through a 2-flop synchronizer. Edge detection uses a registered copy of the synchronized value of the selected channel.
- States:
  - IDLE: if i_enable and i_mask != 0, select the next set mask bit strictly after the last-served id (wrapping; after reset, search starts at bit 0); go to TRIG. Otherwise stay.
  - TRIG: o_trigger[sel] high for exactly TRIG_CYC cycles, then go to WAIT.
  - WAIT: timer counts from 0. On a synchronized rising edge, go to MEAS with timer = 0. If timer reaches TO_CYC first, report a timeout and go to GUARD. An echo already high on WAIT entry does not count; only a fresh 0→1 edge starts MEAS.
  - MEAS: timer counts cycles while the synchronized echo is high. On the falling edge, report o_echo_time = timer and o_timeout = 0. If timer reaches TO_CYC, report o_echo_time = TO_CYC and o_timeout = 1. Either way, go to GUARD.
  - GUARD: wait GRD_CYC cycles, then go to IDLE. Selection is re-evaluated there.
- A report drives o_valid for one cycle and registers o_sensor_id, o_echo_time and o_timeout. These hold until the next report.
- A timeout in WAIT reports o_echo_time = 0, o_timeout = 1.
- i_enable and i_mask are sampled only in IDLE. Changes during a measurement never abort it.
- A mask with a single bit set re-polls that sensor every cycle through the states.

## Timing
- Reset values: o_trigger = 0, o_valid = 0, o_sensor_id = 0, o_echo_time = 0, o_timeout = 0, o_busy = 0, state = IDLE, timer = 0, synchronizers = 0.
- Reset asserted mid-measurement forces all of the above immediately (asynchronous). Trigger drops without waiting for the pulse to finish.
- IDLE→TRIG takes 1 cycle after i_enable is seen; o_trigger rises in the cycle after the selection.
- o_echo_time equals the pin pulse width in cycles, with 0 error for edges aligned to i_clk. Pin-to-internal latency is 2 cycles on both edges.
- o_valid is asserted 3 cycles after the echo pin falls (2 sync + 1 edge register).
- The timer is at 0 in the first cycle of WAIT and of MEAS.
- o_trigger falls on the same edge that WAIT is entered.

## Structure
- Package hcsr04_pkg holds:
  - state enum (IDLE, TRIG, WAIT, MEAS, GUARD)
  - ECHO_W = 22
  - a function converting µs to cycles from T_CLK
- Sub-module hcsr04_rr_pick: combinational next-set-bit-after-index with wrap. Inputs are mask and last id; outputs are the id and a found flag.
- Synchronizers, timer and FSM live in hcsr04_scheduler.

## Test plan
- Mask 4'b0101, echo 1000 µs on ch0 and 2000 µs on ch2 → valid with id 0, time 100000; then id 2, time 200000. Each trigger is exactly 1000 cycles. Consecutive triggers are spaced ≥ 1,000,000 guard cycles apart.
- Mask 4'b0010 with no echo → valid, id 1, o_timeout = 1, time 0, 3,800,000 cycles after the trigger fall.
- Echo held high 40 ms → valid, o_timeout = 1, o_echo_time = 3,800,000.
- Mask switched from 4'b0001 to 4'b1000 during MEAS → ch0 result still reported; next trigger is on ch3.
- i_rstn pulsed low mid-TRIG → o_trigger = 0 and o_busy = 0 immediately. After release, the first trigger is on the lowest set mask bit.
- i_enable = 0 with mask 4'b1111 → no triggers and o_busy = 0 for 10,000 cycles.

Source files
------------

// File: rtl/hcsr04_pkg.sv
// Shared types and helpers for the HC-SR04 round-robin measurement scheduler.
package hcsr04_pkg;

  localparam int ECHO_W = 22;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    TRIG  = 3'd1,
    WAIT  = 3'd2,
    MEAS  = 3'd3,
    GUARD = 3'd4
  } state_t;

  // Microseconds to whole clock cycles; 64-bit intermediate avoids overflow.
  function automatic int us_to_cyc(input int us, input int t_clk_ns);
    longint cyc;
    cyc = (longint'(us) * 64'sd1000) / longint'(t_clk_ns);
    return int'(cyc);
  endfunction

endpackage

// File: rtl/hcsr04_rr_pick.sv
// Round-robin picker: first set mask bit strictly after last_id, wrapping around.
module hcsr04_rr_pick #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   mask,
  input  logic [IDW-1:0] last_id,
  output logic [IDW-1:0] id,
  output logic           found
);

  always_comb begin
    logic [IDW-1:0] cand;
    id    = '0;
    found = 1'b0;
    cand  = '0;
    // Walk from farthest to nearest so the closest candidate wins last.
    for (int k = N; k >= 1; k--) begin
      cand = IDW'((int'(last_id) + k) % N);
      if (mask[cand]) begin
        id    = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hcsr04_scheduler.sv
// Time-multiplexed HC-SR04 controller: trigger, echo timing with timeout, and
// a guard gap between sensors so their bursts never overlap acoustically.
//
// state | meaning
// IDLE  | waiting for i_enable and a non-empty mask; picks next channel
// TRIG  | trigger pin of the selected channel high for TRIG_CYC cycles
// WAIT  | waiting for a fresh echo rise, bounded by TO_CYC
// MEAS  | timing the echo high phase, bounded by TO_CYC
// GUARD | quiet gap of GRD_CYC cycles before the next selection
module hcsr04_scheduler
  import hcsr04_pkg::*;
#(
  parameter  int T_CLK      = 10,
  parameter  int N_SENSORS  = 4,
  parameter  int TRIG_US    = 10,
  parameter  int TIMEOUT_US = 38000,
  parameter  int GUARD_US   = 10000,
  localparam int IDW        = (N_SENSORS > 1) ? $clog2(N_SENSORS) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic                 i_enable,
  input  logic [N_SENSORS-1:0] i_mask,
  input  logic [N_SENSORS-1:0] i_echo,
  output logic [N_SENSORS-1:0] o_trigger,
  output logic                 o_valid,
  output logic [IDW-1:0]       o_sensor_id,
  output logic [ECHO_W-1:0]    o_echo_time,
  output logic                 o_timeout,
  output logic                 o_busy
);

  localparam int TRIG_CYC = us_to_cyc(TRIG_US, T_CLK);
  localparam int TO_CYC   = us_to_cyc(TIMEOUT_US, T_CLK);
  localparam int GRD_CYC  = us_to_cyc(GUARD_US, T_CLK);

  localparam logic [31:0] TRIG_LAST = 32'(TRIG_CYC - 1);
  localparam logic [31:0] TO_LAST   = 32'(TO_CYC - 1);
  localparam logic [31:0] GRD_LAST  = 32'(GRD_CYC - 1);

  if (TO_CYC >= (1 << ECHO_W)) begin : g_bad_timeout
    $error("hcsr04_scheduler: timeout cycle count does not fit the echo time width");
  end
  if (TRIG_CYC < 1 || TO_CYC < 1 || GRD_CYC < 1) begin : g_bad_cycles
    $error("hcsr04_scheduler: trigger, timeout and guard must each be at least one cycle");
  end
  if (N_SENSORS < 1 || N_SENSORS > 8) begin : g_bad_n
    $error("hcsr04_scheduler: N_SENSORS must be in 1..8");
  end

  state_t               state;
  logic [31:0]          timer;
  logic [IDW-1:0]       sel;
  logic [N_SENSORS-1:0] echo_s1;
  logic [N_SENSORS-1:0] echo_s2;
  logic                 echo_q;
  logic                 echo_sel;
  logic                 echo_rise;
  logic                 echo_fall;
  logic [IDW-1:0]       pick_id;
  logic                 pick_found;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      echo_s1 <= '0;
      echo_s2 <= '0;
    end else begin
      echo_s1 <= i_echo;
      echo_s2 <= echo_s1;
    end
  end

  assign echo_sel  = echo_s2[sel];
  assign echo_rise = echo_sel & ~echo_q;
  assign echo_fall = ~echo_sel & echo_q;

  hcsr04_rr_pick #(
    .N   (N_SENSORS),
    .IDW (IDW)
  ) u_pick (
    .mask    (i_mask),
    .last_id (sel),
    .id      (pick_id),
    .found   (pick_found)
  );

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state       <= IDLE;
      timer       <= '0;
      // Parked on the last channel so the first search after reset starts at bit 0.
      sel         <= IDW'(N_SENSORS - 1);
      echo_q      <= 1'b0;
      o_trigger   <= '0;
      o_valid     <= 1'b0;
      o_sensor_id <= '0;
      o_echo_time <= '0;
      o_timeout   <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      echo_q  <= echo_sel;
      o_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (i_enable && pick_found) begin
            sel       <= pick_id;
            o_trigger <= N_SENSORS'(1) << pick_id;
            timer     <= '0;
            o_busy    <= 1'b1;
            state     <= TRIG;
          end
        end
        TRIG: begin
          if (timer == TRIG_LAST) begin
            o_trigger <= '0;
            timer     <= '0;
            state     <= WAIT;
          end else begin
            timer <= timer + 32'd1;
          end
        end
        WAIT: begin
          if (echo_rise) begin
            timer <= '0;
            state <= MEAS;
          end else if (timer == TO_LAST) begin
            o_valid     <= 1'b1;
            o_sensor_id <= sel;
            o_echo_time <= '0;
            o_timeout   <= 1'b1;
            timer       <= '0;
            state       <= GUARD;
          end else begin
            timer <= timer + 32'd1;
          end
        end
        MEAS: begin
          // The cycle that raised the edge is not in timer, hence the +1.
          if (echo_fall) begin
            o_valid     <= 1'b1;
            o_sensor_id <= sel;
            o_echo_time <= ECHO_W'(timer + 32'd1);
            o_timeout   <= 1'b0;
            timer       <= '0;
            state       <= GUARD;
          end else if (timer == TO_LAST) begin
            o_valid     <= 1'b1;
            o_sensor_id <= sel;
            o_echo_time <= ECHO_W'(TO_CYC);
            o_timeout   <= 1'b1;
            timer       <= '0;
            state       <= GUARD;
          end else begin
            timer <= timer + 32'd1;
          end
        end
        GUARD: begin
          if (timer == GRD_LAST) begin
            timer  <= '0;
            o_busy <= 1'b0;
            state  <= IDLE;
          end else begin
            timer <= timer + 32'd1;
          end
        end
        default: begin
          o_trigger <= '0;
          timer     <= '0;
          o_busy    <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hcsr04_scheduler.sv
// Randomized bench for hcsr04_scheduler with a behavioural sensor and result model.
module tb_hcsr04_scheduler;

  localparam int N          = 4;
  localparam int T_CLK      = 1000;
  localparam int TRIG_US    = 10;
  localparam int TIMEOUT_US = 300;
  localparam int GUARD_US   = 50;
  localparam int TRIG_CYC   = TRIG_US * 1000 / T_CLK;
  localparam int TO_CYC     = TIMEOUT_US * 1000 / T_CLK;
  localparam int GRD_CYC    = GUARD_US * 1000 / T_CLK;

  logic        clk;
  logic        rstn;
  logic        enable;
  logic [3:0]  mask;
  logic [3:0]  echo;
  logic [3:0]  trigger;
  logic        valid;
  logic [1:0]  sensor_id;
  logic [21:0] echo_time;
  logic        timeout;
  logic        busy;

  int n_chk;
  int n_fail;
  int last_ch;
  bit first_meas;

  hcsr04_scheduler #(
    .T_CLK      (T_CLK),
    .N_SENSORS  (N),
    .TRIG_US    (TRIG_US),
    .TIMEOUT_US (TIMEOUT_US),
    .GUARD_US   (GUARD_US)
  ) dut (
    .i_clk       (clk),
    .i_rstn      (rstn),
    .i_enable    (enable),
    .i_mask      (mask),
    .i_echo      (echo),
    .o_trigger   (trigger),
    .o_valid     (valid),
    .o_sensor_id (sensor_id),
    .o_echo_time (echo_time),
    .o_timeout   (timeout),
    .o_busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Next channel to serve: first set bit strictly after the last served one.
  function automatic int next_ch(input logic [3:0] m, input int last);
    for (int i = 1; i <= N; i++) begin
      int c;
      c = (last + i) % N;
      if (m[c]) return c;
    end
    return -1;
  endfunction

  // mode: 0 echo pulse, 1 no echo, 2 echo stuck high, 3 echo already high before WAIT
  task automatic do_one(input int mode, input int dly, input int wid,
                        input int chg_k, input logic [3:0] chg_mask);
    int ch, n, k;
    bit got;
    logic [3:0] exp_trig;
    ch  = next_ch(mask, last_ch);
    n   = 0;
    got = 1'b0;
    for (int i = 0; i < GRD_CYC + TO_CYC + 100; i++) begin
      if (trigger != 4'b0) begin
        got = 1'b1;
        break;
      end
      step();
      n++;
    end
    if (!got) begin
      chk("trig_wait", 0, 1);
      return;
    end
    if (!first_meas) chk("guard_gap_min", (n >= GRD_CYC) ? 1 : 0, 1);
    exp_trig = 4'b0001 << ch;
    chk("trig_ch", trigger, exp_trig);
    chk("busy_trig", busy, 1);
    last_ch    = ch;
    first_meas = 1'b0;
    if (mode == 3) echo[ch] = 1'b1;
    n = 1;
    for (int i = 0; i < TRIG_CYC + 20; i++) begin
      step();
      if (trigger == 4'b0) break;
      n++;
    end
    chk("trig_len", n, TRIG_CYC);
    got = 1'b0;
    for (k = 1; k <= TO_CYC + dly + wid + 20; k++) begin
      case (mode)
        0:       echo[ch] = (k > dly) && (k <= dly + wid);
        1:       echo[ch] = 1'b0;
        default: echo[ch] = (mode == 3) || (k > dly);
      endcase
      if (k == chg_k) mask = chg_mask;
      step();
      if (valid) begin
        got = 1'b1;
        break;
      end
    end
    echo = 4'b0;
    chk("valid_seen", got, 1);
    if (!got) return;
    chk("result_id", sensor_id, ch);
    case (mode)
      0: begin
        chk("valid_latency", k, dly + wid + 3);
        chk("echo_time", echo_time, wid);
        chk("timeout_flag", timeout, 0);
      end
      2: begin
        chk("echo_time_to", echo_time, TO_CYC);
        chk("timeout_flag", timeout, 1);
      end
      default: begin
        chk("wait_to_latency", k, TO_CYC);
        chk("echo_time_wait_to", echo_time, 0);
        chk("timeout_flag", timeout, 1);
      end
    endcase
    step();
    chk("valid_pulse", valid, 0);
  endtask

  initial begin
    int cnt_trig, cnt_busy, mode, dly, wid;
    bit got;
    n_chk = 0;
    n_fail = 0;
    last_ch = -1;
    first_meas = 1'b1;
    rstn = 1'b0;
    enable = 1'b0;
    mask = 4'b0;
    echo = 4'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_trigger", trigger, 0);
    chk("rst_valid", valid, 0);
    chk("rst_id", sensor_id, 0);
    chk("rst_time", echo_time, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rstn = 1'b1;

    mask = 4'b0101;
    enable = 1'b1;
    do_one(0, 3, 100, 0, 4'b0);
    do_one(0, 7, 200, 0, 4'b0);
    mask = 4'b0010;
    do_one(1, 0, 0, 0, 4'b0);
    do_one(2, 4, 0, 0, 4'b0);
    do_one(3, 0, 0, 0, 4'b0);
    mask = 4'b1000;
    do_one(0, 1, 1, 0, 4'b0);
    do_one(0, 2, TO_CYC - 1, 0, 4'b0);
    mask = 4'b0001;
    do_one(0, 5, 100, 35, 4'b1000);
    do_one(0, 2, 50, 0, 4'b0);

    for (int it = 0; it < 14; it++) begin
      mask = 4'($urandom_range(1, 15));
      mode = $urandom_range(0, 9);
      dly  = $urandom_range(1, 20);
      wid  = $urandom_range(1, TO_CYC - 1);
      if (mode <= 6)      do_one(0, dly, wid, 0, 4'b0);
      else if (mode == 7) do_one(1, 0, 0, 0, 4'b0);
      else if (mode == 8) do_one(2, dly, 0, 0, 4'b0);
      else                do_one(3, 0, 0, 0, 4'b0);
    end

    enable = 1'b0;
    mask = 4'b1111;
    repeat (GRD_CYC + 5) step();
    cnt_trig = 0;
    cnt_busy = 0;
    for (int i = 0; i < 10000; i++) begin
      step();
      if (trigger != 4'b0) cnt_trig++;
      if (busy) cnt_busy++;
    end
    chk("disabled_triggers", cnt_trig, 0);
    chk("disabled_busy", cnt_busy, 0);

    mask = 4'b0110;
    enable = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (trigger != 4'b0) begin
        got = 1'b1;
        break;
      end
    end
    chk("pre_rst_trig", got, 1);
    repeat (3) @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    chk("midrst_trigger", trigger, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", valid, 0);
    chk("midrst_time", echo_time, 0);
    chk("midrst_id", sensor_id, 0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    last_ch = -1;
    first_meas = 1'b1;
    do_one(0, 3, 40, 0, 4'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
